// File: rtl/cla_add_seq_pkg.sv
// Shared types and constants for the byte-serial carry-lookahead add sequencer.
// Optional subtract support is selected with the CLA_ADD_SEQ_SUB_EN macro.
package cla_add_seq_pkg;

    localparam int WORDS_DEF = 4;
    localparam int WORDS_MIN = 1;
    localparam int WORDS_MAX = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Raw state encodings used by the state register.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Byte-index register width; a single-byte operand still needs one bit.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_width(WORDS_DEF);

endpackage

// File: rtl/cla_add_seq_if.sv
// Operand/result bus of the add sequencer; the sub line exists only with CLA_ADD_SEQ_SUB_EN.
// Handshake: a transfer happens on a rising edge where valid && ready; the master holds its
// payload stable while valid is high and unanswered, and ready never depends on valid.
interface cla_add_seq_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
`ifdef CLA_ADD_SEQ_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    modport master (
`ifdef CLA_ADD_SEQ_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
`ifdef CLA_ADD_SEQ_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );

endinterface

// File: rtl/cla_add_seq_cla8.sv
// 8-bit carry-lookahead adder: every carry is a flat sum of generate/propagate products,
// so no carry ripples through a previous carry.
module cla8 (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       run_p;

    assign g = x & y;
    assign p = x ^ y;

    // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]ci
    always_comb begin
        c     = '0;
        run_p = 1'b0;
        c[0]  = ci;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i];
            run_p  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (run_p & g[j]);
                run_p  = run_p & p[j];
            end
            c[i+1] = c[i+1] | (run_p & ci);
        end
    end

    assign s  = p ^ c[7:0];
    assign co = c[8];

endmodule

// File: rtl/cla_add_seq.sv
// Multi-precision add sequencer: one shared cla8 processes the operands one byte per cycle,
// LSB first, with a registered inter-byte carry. Subtract exists only with CLA_ADD_SEQ_SUB_EN.
module cla_add_seq
    import cla_add_seq_pkg::*;
#(
    parameter int WORDS = WORDS_DEF
) (
    input  logic           clk,
    input  logic           rst,
    cla_add_seq_if.slave   bus,
    output state_e         state_dbg
);

    localparam int N     = 8 * WORDS;
    localparam int IDX_W = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    logic [1:0]             state_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   carry_q;
    logic [WORDS-1:0][7:0]  a_q;
    logic [WORDS-1:0][7:0]  b_q;
    logic [WORDS-1:0][7:0]  sum_q;
    logic                   cout_q;
    logic                   ovf_q;
    logic                   out_valid_q;

    logic [N-1:0]           b_eff;
    logic                   c_init;
    logic [7:0]             add_x;
    logic [7:0]             add_y;
    logic [7:0]             add_s;
    logic                   add_co;
    logic                   last;

    // Subtraction is A + ~B + 1, so inversion and the forced carry happen at latch time.
`ifdef CLA_ADD_SEQ_SUB_EN
    assign b_eff  = bus.sub ? ~bus.b : bus.b;
    assign c_init = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_eff  = bus.b;
    assign c_init = bus.cin;
`endif

    assign add_x = a_q[idx_q];
    assign add_y = b_q[idx_q];
    assign last  = (idx_q == LAST_IDX);

    cla8 u_cla8 (
        .x  (add_x),
        .y  (add_y),
        .ci (carry_q),
        .s  (add_s),
        .co (add_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= b_eff;
                        carry_q <= c_init;
                        idx_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q[idx_q] <= add_s;
                    carry_q      <= add_co;
                    if (last) begin
                        // Adder inputs hold the MSB bytes here, so their bit 7 are the sign bits.
                        cout_q      <= add_co;
                        ovf_q       <= (add_x[7] == add_y[7]) && (add_s[7] != add_x[7]);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // in_ready and busy decode only the state register.
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign state_dbg     = state_e'(state_q);

endmodule

// File: doc/cla_add_seq.md
# cla_add_seq

Multi-precision add sequencer that runs operands of WORDS bytes through a single shared 8-bit carry-lookahead adder, one byte per cycle from LSB to MSB. The carry between bytes is registered. Operands are accepted and results returned over valid/ready handshakes. The block sits between operand producers (register file / ALU front end) and result consumers, and is the only master of the 8-bit adder.

## Interface
Parameters:
- WORDS, 4, operand width in bytes (1..16); total width N = 8*WORDS

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- a  in  N  operand A
- b  in  N  operand B
- cin  in  1  initial carry into byte 0
- sub  in  1  subtract request (present only with CLA_ADD_SEQ_SUB_EN)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum  out  N  result
- cout  out  1  carry out of MSB byte
- ovf  out  1  signed overflow of full-width result
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a, b, cin (and sub); clear idx; go to RUN.
- RUN:
  - Adder inputs: A byte[idx], B byte[idx], carry register.
  - Each cycle: write sum byte[idx]; carry_reg <= adder carry; idx++.
  - When idx==WORDS-1: also capture ovf = (a_msb==b_eff_msb) && (sum_msb!=a_msb); go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf held stable.
  - On out_ready: go to IDLE.
- in_ready=0 in RUN and DONE. Operands arriving then are neither accepted nor latched. Input changes during RUN have no effect.
- No overlap: a new operation can only be accepted after the result handshake completes.
- Arithmetic is modulo 2^N. cout is the carry out of bit N-1.
- Reset values: state=IDLE, in_ready=1 (combinational from IDLE), out_valid=0, busy=0, sum=0, cout=0, ovf=0, idx=0, carry_reg=0.
- Reset mid-operation (RUN or DONE): operation aborted, no out_valid pulse, all outputs return to reset values on the next cycle.
- WORDS=1: RUN lasts exactly one cycle.

## Timing
- Acceptance cycle T (in_valid && in_ready sampled high).
- RUN occupies cycles T+1 .. T+WORDS.
- out_valid rises in cycle T+WORDS+1. Latency is WORDS+1 cycles.
- Earliest next acceptance is the cycle after the out_ready handshake. Peak throughput is one operation per WORDS+2 cycles.
- out_valid/sum/cout/ovf are registered outputs. in_ready is a combinational decode of the state register only; there is no combinational path from in_valid or out_ready.

## Configuration
- CLA_ADD_SEQ_SUB_EN defined:
  - sub port exists.
  - When sub=1 is latched: B is bitwise inverted per byte and the initial carry is forced to 1, so cin is ignored and the result is A-B.
  - cout=1 means no borrow.
  - ovf uses the inverted B MSB.
- Undefined: no sub port; add-only; b_eff=b.

## Structure
- Package cla_add_seq_pkg:
  - state enum (IDLE, RUN, DONE)
  - WORDS default and limits
  - index width constant $clog2(WORDS) (minimum 1)
- Sub-module cla8: 8-bit carry-lookahead adder.
  - Inputs: x[7:0], y[7:0], ci.
  - Outputs: s[7:0], co.
  - Generate/propagate lookahead with full carry expansion.
  - Instantiated once.
- Top holds the FSM, operand registers, byte mux, carry register and result register.

## Test plan
- WORDS=4: a=0xFFFFFFFF, b=0x00000001, cin=0. Expect sum=0x00000000, cout=1, ovf=0, out_valid exactly at T+5.
- a=0x12345678, b=0x11111111, cin=1. Expect sum=0x2345678A, cout=0, ovf=0.
- a=0x7FFFFFFF, b=0x00000001. Expect sum=0x80000000, ovf=1, cout=0.
- Backpressure: hold out_ready=0 for 6 cycles in DONE.
  - sum/cout stay stable; in_ready stays 0.
  - in_valid pulsed during that window is not accepted.
  - After out_ready, the next in_valid is accepted.
- Reset asserted at T+2 during RUN. Expect out_valid never rises, sum=0, in_ready=1 the cycle after reset deasserts.
- With CLA_ADD_SEQ_SUB_EN: a=5, b=7, sub=1. Expect sum=0xFFFFFFFE, cout=0. Then a=7, b=5. Expect sum=0x00000002, cout=1.
